// File: rtl/job_supervisor_pkg.sv
// rtl/job_supervisor_pkg.sv - shared state encoding and response status codes for the job supervisor
package job_supervisor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RUN,
        ST_KILL,
        ST_RECOVER,
        ST_REPORT
    } state_t;

    localparam logic [1:0] STAT_OK        = 2'b00;
    localparam logic [1:0] STAT_TIMEOUT   = 2'b01;
    localparam logic [1:0] STAT_CANCELLED = 2'b10;

    // Quiet cycles with kill low so the worker settles before a relaunch or report.
    localparam int unsigned RECOVER_CYCLES = 2;

endpackage

// File: rtl/job_supervisor_timer.sv
// rtl/job_supervisor_timer.sv - saturating RUN-phase cycle timer with terminal-count compare
module sup_timeout_timer #(
    parameter int unsigned TIMEOUT = 128
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_expired = (r_count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/job_supervisor.sv
// rtl/job_supervisor.sv - launches a worker job, detects hangs, kills and optionally retries (JOB_SUPERVISOR_RETRY_EN)
module job_supervisor
    import job_supervisor_pkg::*;
#(
    parameter int unsigned TIMEOUT     = 128,
    parameter int unsigned MAX_RETRY   = 2,
    parameter int unsigned KILL_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cancel,
    input  logic       done_in,
    output logic       go,
    output logic       kill,
    output logic       busy,
    output logic       resp_valid,
    output logic [1:0] resp_status,
    output logic [1:0] resp_retries
);

    state_t     r_state;
    logic [3:0] r_phase;
    logic [1:0] r_status;
    logic       r_go;
    logic       r_kill;
    logic       r_busy;
    logic       r_resp_valid;
    logic       w_tmr_clear;
    logic       w_tmr_enable;
    logic       w_expired;
`ifdef JOB_SUPERVISOR_RETRY_EN
    logic [1:0] r_retry;
`endif

    assign w_tmr_clear  = (r_state == ST_ISSUE);
    assign w_tmr_enable = (r_state == ST_RUN);

    sup_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_enable),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_phase      <= 4'd0;
            r_status     <= STAT_OK;
            r_go         <= 1'b0;
            r_kill       <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
`ifdef JOB_SUPERVISOR_RETRY_EN
            r_retry      <= 2'd0;
`endif
        end else begin
            r_go         <= 1'b0;
            r_resp_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_ISSUE;
                        r_go     <= 1'b1;
                        r_busy   <= 1'b1;
                        r_status <= STAT_OK;
`ifdef JOB_SUPERVISOR_RETRY_EN
                        r_retry  <= 2'd0;
`endif
                    end
                end
                ST_ISSUE: r_state <= ST_RUN;
                ST_RUN: begin
                    // A relaunched job that completes reports OK, not the earlier timeout.
                    if (done_in) begin
                        r_state      <= ST_REPORT;
                        r_status     <= STAT_OK;
                        r_resp_valid <= 1'b1;
                    end else if (cancel) begin
                        r_state  <= ST_KILL;
                        r_kill   <= 1'b1;
                        r_phase  <= 4'd0;
                        r_status <= STAT_CANCELLED;
                    end else if (w_expired) begin
                        r_state  <= ST_KILL;
                        r_kill   <= 1'b1;
                        r_phase  <= 4'd0;
                        r_status <= STAT_TIMEOUT;
                    end
                end
                ST_KILL: begin
                    if (r_phase == 4'(KILL_CYCLES - 1)) begin
                        r_state <= ST_RECOVER;
                        r_kill  <= 1'b0;
                        r_phase <= 4'd0;
                    end else begin
                        r_phase <= r_phase + 4'd1;
                    end
                end
                ST_RECOVER: begin
                    if (r_phase == 4'(RECOVER_CYCLES - 1)) begin
`ifdef JOB_SUPERVISOR_RETRY_EN
                        if ((r_status == STAT_TIMEOUT) && (r_retry < 2'(MAX_RETRY))) begin
                            r_state <= ST_ISSUE;
                            r_go    <= 1'b1;
                            r_retry <= r_retry + 2'd1;
                        end else begin
                            r_state      <= ST_REPORT;
                            r_resp_valid <= 1'b1;
                        end
`else
                        r_state      <= ST_REPORT;
                        r_resp_valid <= 1'b1;
`endif
                    end else begin
                        r_phase <= r_phase + 4'd1;
                    end
                end
                ST_REPORT: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_kill  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign go          = r_go;
    assign kill        = r_kill;
    assign busy        = r_busy;
    assign resp_valid  = r_resp_valid;
    assign resp_status = r_status;
`ifdef JOB_SUPERVISOR_RETRY_EN
    assign resp_retries = r_retry;
`else
    // MAX_RETRY has no effect in this build; the mask pins the count at 00.
    assign resp_retries = 2'(MAX_RETRY) & 2'b00;
`endif

endmodule

// File: tb/tb_job_supervisor.sv
// tb/tb_job_supervisor.sv - randomized and directed bench with a job-level reference model
module tb_job_supervisor;

    localparam int TIMEOUT     = 128;
    localparam int MAX_RETRY   = 2;
    localparam int KILL_CYCLES = 2;
`ifdef JOB_SUPERVISOR_RETRY_EN
    localparam int EXP_LAUNCHES = 3;
    localparam int EXP_RETRIES  = 2;
`else
    localparam int EXP_LAUNCHES = 1;
    localparam int EXP_RETRIES  = 0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       cancel = 1'b0;
    logic       done_in = 1'b0;
    logic       go, kill, busy, resp_valid;
    logic [1:0] resp_status, resp_retries;

    always #5 clk = ~clk;

    job_supervisor #(
        .TIMEOUT     (TIMEOUT),
        .MAX_RETRY   (MAX_RETRY),
        .KILL_CYCLES (KILL_CYCLES)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cancel       (cancel),
        .done_in      (done_in),
        .go           (go),
        .kill         (kill),
        .busy         (busy),
        .resp_valid   (resp_valid),
        .resp_status  (resp_status),
        .resp_retries (resp_retries)
    );

    int checks = 0;
    int failures = 0;
    bit e_go, e_kill, e_busy, e_rv;
    int e_status, e_retries;
    int ncyc = 0;
    int go_times[$];
    int kill_cnt, rv_cnt, last_status, last_retries;

    task automatic emit(input bit g, input bit k, input bit b, input bit v, input int s, input int r);
        e_go = g; e_kill = k; e_busy = b; e_rv = v; e_status = s; e_retries = r;
    endtask

    task automatic tick(output bit a);
        @(posedge clk);
        a = reset;
        if (a) emit(0, 0, 0, 0, 0, 0);
    endtask

    // Job-level reference: walks one job at a time, sampling inputs at each edge.
    initial begin : model_proc
        bit ab;
        int retries;
        int outcome;
        emit(0, 0, 0, 0, 0, 0);
        forever begin
            emit(0, 0, 0, 0, 0, 0);
            ab = 0;
            forever begin
                tick(ab);
                if (ab || start) break;
            end
            if (ab) continue;
            retries = 0;
            forever begin
                emit(1, 0, 1, 0, 0, 0);
                tick(ab);
                if (ab) break;
                emit(0, 0, 1, 0, 0, 0);
                outcome = 3;
                for (int t = 0; t < TIMEOUT; t++) begin
                    tick(ab);
                    if (ab) break;
                    if (done_in) begin outcome = 1; break; end
                    if (cancel) begin outcome = 2; break; end
                end
                if (ab) break;
                if (outcome != 1) begin
                    emit(0, 1, 1, 0, 0, 0);
                    for (int k = 0; k < KILL_CYCLES && !ab; k++) tick(ab);
                    if (ab) break;
                    emit(0, 0, 1, 0, 0, 0);
                    for (int k = 0; k < 2 && !ab; k++) tick(ab);
                    if (ab) break;
`ifdef JOB_SUPERVISOR_RETRY_EN
                    if (outcome == 3 && retries < MAX_RETRY) begin
                        retries++;
                        continue;
                    end
`endif
                end
                emit(0, 0, 1, 1, (outcome == 1) ? 0 : ((outcome == 2) ? 2 : 1), retries);
                tick(ab);
                break;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        go_times.delete();
        kill_cnt = 0; rv_cnt = 0; last_status = -1; last_retries = -1;
    endtask

    task automatic wait_go(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (go) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("wait_go", ok, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("wait_idle", ok, 1);
    endtask

    task automatic pulse_start();
        start = 1; @(negedge clk); start = 0;
    endtask

    task automatic check_job(input string name, input int launches, input int kills, input int st, input int rt);
        chk({name, "_go_pulses"}, go_times.size(), launches);
        chk({name, "_kill_cycles"}, kill_cnt, kills);
        chk({name, "_resp_count"}, rv_cnt, 1);
        chk({name, "_status"}, last_status, st);
        chk({name, "_retries"}, last_retries, rt);
    endtask

    initial begin
        int n;
        fork
            forever begin
                @(negedge clk);
                ncyc++;
                chk("cycle_go_kill_busy_valid", {go, kill, busy, resp_valid}, {e_go, e_kill, e_busy, e_rv});
                if (e_rv) begin
                    chk("cycle_status", resp_status, e_status);
                    chk("cycle_retries", resp_retries, e_retries);
                end
                if (go) go_times.push_back(ncyc);
                if (kill) kill_cnt++;
                if (resp_valid) begin
                    rv_cnt++; last_status = resp_status; last_retries = resp_retries;
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("reset_outputs", {go, kill, busy, resp_valid}, 0);
        chk("reset_status", resp_status, 0);
        chk("reset_retries", resp_retries, 0);
        #1 reset = 0;
        @(negedge clk);

        clear_mon(); pulse_start(); wait_go(10);
        repeat (104) @(negedge clk);
        done_in = 1; @(negedge clk); done_in = 0;
        wait_idle(300);
        check_job("done104", 1, 0, 0, 0);

        clear_mon(); pulse_start(); wait_go(10);
        wait_idle(1000);
        check_job("hang", EXP_LAUNCHES, EXP_LAUNCHES * KILL_CYCLES, 1, EXP_RETRIES);
        if (go_times.size() >= 2) chk("hang_go_spacing", go_times[1] - go_times[0], 133);

        clear_mon(); pulse_start(); wait_go(10);
        repeat (50) @(negedge clk);
        cancel = 1; @(negedge clk); cancel = 0;
        wait_idle(300);
        check_job("cancel50", 1, 2, 2, 0);

        clear_mon(); pulse_start(); wait_go(10);
        repeat (20) @(negedge clk);
        cancel = 1; done_in = 1; @(negedge clk); cancel = 0; done_in = 0;
        wait_idle(300);
        check_job("done_and_cancel", 1, 0, 0, 0);

        clear_mon(); pulse_start(); wait_go(10);
        repeat (128) @(negedge clk);
        done_in = 1; @(negedge clk); done_in = 0;
        wait_idle(300);
        check_job("done_last_cycle", 1, 0, 0, 0);

        clear_mon(); pulse_start(); wait_go(10);
        repeat (61) @(negedge clk);
        #1 reset = 1;
        #1 chk("midjob_reset_outputs", {go, kill, busy, resp_valid}, 0);
        repeat (2) @(negedge clk);
        #1 reset = 0;
        @(negedge clk);
        chk("midjob_reset_no_kill", kill_cnt, 0);
        chk("midjob_reset_no_resp", rv_cnt, 0);
        clear_mon(); pulse_start(); wait_go(10);
        repeat (10) @(negedge clk);
        done_in = 1; @(negedge clk); done_in = 0;
        wait_idle(300);
        check_job("after_reset", 1, 0, 0, 0);

        start = 1; done_in = 1;
        wait_go(10);
        n = 0;
        do begin @(negedge clk); n++; end while (!go && n < 20);
        chk("back_to_back_go_gap", n, 4);
        start = 0;
        wait_idle(300);
        done_in = 0;
        @(negedge clk);

        for (int i = 0; i < 5000; i++) begin
            start   = ($urandom % 6) == 0;
            cancel  = ($urandom % 200) == 0;
            done_in = ($urandom % 160) == 0;
            @(negedge clk);
        end
        start = 0; cancel = 0; done_in = 0;
        wait_idle(1000);
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/job_supervisor.md
JOB_SUPERVISOR -- requirements
Module: job_supervisor

Interface
REQ-001 Parameter TIMEOUT, default 128: RUN-phase cycles allowed before the job is declared hung; legal range 2..255.
REQ-002 Parameter MAX_RETRY, default 2: maximum re-launches after a timeout; legal range 0..3.
REQ-003 Parameter KILL_CYCLES, default 2: cycles kill is held high; legal range 1..15.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  job request, sampled in IDLE only.
REQ-007 cancel  input  1  software abort, sampled in RUN only.
REQ-008 done_in  input  1  single-cycle completion pulse from the worker.
REQ-009 go  output  1  one-cycle launch pulse to the worker.
REQ-010 kill  output  1  abort level to the worker.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 resp_valid  output  1  one-cycle result strobe.
REQ-013 resp_status  output  2  00 OK, 01 TIMEOUT, 10 CANCELLED; valid with resp_valid.
REQ-014 resp_retries  output  2  number of re-launches used; valid with resp_valid.

Function
REQ-015 FSM states: IDLE, ISSUE, RUN, KILL, RECOVER, REPORT; all outputs registered.
REQ-016 IDLE: start=1 -> ISSUE; retry counter and status cleared.
REQ-017 ISSUE: go=1 for exactly this one cycle; timer cleared; next state RUN unconditionally.
REQ-018 RUN: timer increments each cycle, saturating at 255; done_in=1 -> REPORT with status OK.
REQ-019 RUN: cancel=1 with done_in=0 -> KILL with status CANCELLED.
REQ-020 RUN: timer==TIMEOUT-1 with done_in=0 and cancel=0 -> KILL with status TIMEOUT.
REQ-021 Priority on simultaneous events in RUN: done_in over cancel over timeout.
REQ-022 KILL: kill=1 for KILL_CYCLES cycles, then -> RECOVER; go held 0.
REQ-023 RECOVER: kill=0 for 2 cycles so the worker returns to idle, then the retry decision.
REQ-024 Retry decision: status TIMEOUT and retry count < MAX_RETRY -> retry count +1 and ISSUE; otherwise REPORT.
REQ-025 REPORT: resp_valid=1 for one cycle with resp_status/resp_retries; next state IDLE.
REQ-026 start outside IDLE, cancel outside RUN, and done_in outside RUN are ignored; there is no queueing.
REQ-027 busy falls in the cycle after REPORT; a start in that cycle launches a new job.

Reset
REQ-028 Reset forces IDLE, timer 0, retry count 0, go=0, kill=0, busy=0, resp_valid=0, resp_status=00, resp_retries=00.
REQ-029 Reset asserted mid-job aborts immediately with no kill or response issued; the worker shares the same reset.

Configuration
REQ-030 Macro JOB_SUPERVISOR_RETRY_EN defined: retry behaviour per REQ-024.
REQ-031 Macro undefined: MAX_RETRY is ignored, every timeout goes KILL -> RECOVER -> REPORT, resp_retries is constant 00, and the retry counter is not synthesized.

Structure
REQ-032 Package job_supervisor_pkg holds the state enum and the status constants STAT_OK, STAT_TIMEOUT and STAT_CANCELLED.
REQ-033 One sub-module sup_timeout_timer (clear, enable, terminal-count compare) is natural; the FSM stays in job_supervisor.

Verification (TIMEOUT=128, MAX_RETRY=2, KILL_CYCLES=2, macro defined unless stated)
REQ-034 start pulse, done_in 104 cycles after go -> single go pulse, resp_valid with status 00 and retries 0, kill never high.
REQ-035 start, done_in never returned -> 3 go pulses each followed by kill high 2 cycles, go spacing 128+2+2+1 cycles, final resp_valid with status 01 and retries 2.
REQ-036 cancel 50 cycles after go -> kill high 2 cycles, no re-launch, resp_valid with status 10 and retries 0.
REQ-037 done_in and cancel in the same cycle, and separately done_in in cycle 127 of RUN -> status 00, no kill.
REQ-038 reset asserted 60 cycles into RUN -> all outputs 0 next edge; a new start after release -> normal job with retries 0.
REQ-039 Macro undefined, no done_in -> one go, one kill burst, resp_valid with status 01 and retries 0.
